iorq_wr_fsm: RTL and testbench

- Write-side counterpart of the VDP I/O read FSM. Samples the Z8S180 bus on phi and detects each external I/O write cycle (IORQ and WR asserted, port selected).
- Latches the data byte and emits exactly one commit pulse per cycle.
- Decodes TMS9918-style port semantics: mode 0 is a data-port byte; mode 1 is the two-byte control sequence (register write or VRAM address setup).
- Feeds the VDP register file and the VRAM address counter.

---
 rtl/vdp_bus_pkg.sv | 37 +++
 rtl/vdp_ctl_latch.sv | 96 +++++++++
 rtl/iorq_wr_fsm.sv | 107 ++++++++++
 tb/tb_iorq_wr_fsm.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vdp_bus_pkg
// Description : Shared definitions for the VDP Z8S180 bus-side FSMs: state
//               encodings for the I/O read and write FSMs and control-byte
//               bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package vdp_bus_pkg;

    localparam int STATE_W = 3;

    // Write-side bus FSM states
    typedef enum logic [STATE_W-1:0] {
        WR_BLOCK  = 3'd0,
        WR_IDLE   = 3'd1,
        WR_ARM    = 3'd2,
        WR_COMMIT = 3'd3,
        WR_HOLD   = 3'd4
    } wr_state_t;

    // Read-side bus FSM states
    typedef enum logic [STATE_W-1:0] {
        RD_BLOCK = 3'd0,
        RD_IDLE  = 3'd1,
        RD_ARM   = 3'd2,
        RD_FETCH = 3'd3,
        RD_HOLD  = 3'd4
    } rd_state_t;

    // Second control byte: bit 7 selects register write, bit 6 selects
    // VRAM write setup (as opposed to read setup)
    localparam int CTL_REG_BIT = 7;
    localparam int CTL_WR_BIT  = 6;

endpackage
`default_nettype wire

// File: rtl/vdp_ctl_latch.sv
`default_nettype none
// ============================================================================
// Module      : vdp_ctl_latch
// Description : TMS9918-style port decode. Holds the control-port toggle and
//               first-byte latch, and turns each committed write into a data,
//               register or VRAM-address update with a one-cycle tick.
// Revision    : 1.0 - initial release
// ============================================================================
module vdp_ctl_latch
    import vdp_bus_pkg::*;
#(
    parameter int REG_BITS  = 3,
    parameter int ADDR_BITS = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_commit,
    input  logic                 i_mode,
    input  logic [7:0]           i_d,
    input  logic                 i_rd_reset,
    output logic                 o_data_tick,
    output logic [7:0]           o_data_val,
    output logic                 o_reg_tick,
    output logic [REG_BITS-1:0]  o_reg_num,
    output logic [7:0]           o_reg_val,
    output logic                 o_addr_tick,
    output logic [ADDR_BITS-1:0] o_addr_val,
    output logic                 o_addr_wr,
    output logic                 o_toggle
);

    logic                 r_data_tick;
    logic [7:0]           r_data_val;
    logic                 r_reg_tick;
    logic [REG_BITS-1:0]  r_reg_num;
    logic [7:0]           r_first;
    logic                 r_addr_tick;
    logic [ADDR_BITS-1:0] r_addr_val;
    logic                 r_addr_wr;
    logic                 r_toggle;

    // Decode the committed byte using the pre-edge toggle; a read-side reset
    // overrides whatever toggle value the decode would have produced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_tick <= 1'b0;
            r_data_val  <= '0;
            r_reg_tick  <= 1'b0;
            r_reg_num   <= '0;
            r_first     <= '0;
            r_addr_tick <= 1'b0;
            r_addr_val  <= '0;
            r_addr_wr   <= 1'b0;
            r_toggle    <= 1'b0;
        end else begin
            r_data_tick <= 1'b0;
            r_reg_tick  <= 1'b0;
            r_addr_tick <= 1'b0;
            if (i_commit) begin
                if (!i_mode) begin
                    r_data_val  <= i_d;
                    r_data_tick <= 1'b1;
                    r_toggle    <= 1'b0;
                end else if (!r_toggle) begin
                    r_first  <= i_d;
                    r_toggle <= 1'b1;
                end else begin
                    if (i_d[CTL_REG_BIT]) begin
                        r_reg_num  <= i_d[REG_BITS-1:0];
                        r_reg_tick <= 1'b1;
                    end else begin
                        r_addr_val  <= {i_d[ADDR_BITS-9:0], r_first};
                        r_addr_wr   <= i_d[CTL_WR_BIT];
                        r_addr_tick <= 1'b1;
                    end
                    r_toggle <= 1'b0;
                end
            end
            if (i_rd_reset) begin
                r_toggle <= 1'b0;
            end
        end
    end

    assign o_data_tick = r_data_tick;
    assign o_data_val  = r_data_val;
    assign o_reg_tick  = r_reg_tick;
    assign o_reg_num   = r_reg_num;
    assign o_reg_val   = r_first;
    assign o_addr_tick = r_addr_tick;
    assign o_addr_val  = r_addr_val;
    assign o_addr_wr   = r_addr_wr;
    assign o_toggle    = r_toggle;

endmodule
`default_nettype wire

// File: rtl/iorq_wr_fsm.sv
`default_nettype none
// ============================================================================
// Module      : iorq_wr_fsm
// Description : Z8S180 external I/O write detector for the VDP. Qualifies
//               IORQ & WR & CE over two phi samples, commits the bus byte
//               exactly once per cycle and hands it to the port decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module iorq_wr_fsm
    import vdp_bus_pkg::*;
#(
    parameter int REG_BITS  = 3,
    parameter int ADDR_BITS = 14
) (
    input  logic                 phi,
    input  logic                 reset,
    input  logic                 iorq,
    input  logic                 wr,
    input  logic                 ce,
    input  logic                 mode,
    input  logic [7:0]           d,
    input  logic                 rd_reset,
    output logic                 wr_tick,
    output logic                 data_tick,
    output logic [7:0]           data_val,
    output logic                 reg_tick,
    output logic [REG_BITS-1:0]  reg_num,
    output logic [7:0]           reg_val,
    output logic                 addr_tick,
    output logic [ADDR_BITS-1:0] addr_val,
    output logic                 addr_wr,
    output logic                 toggle
);

    wr_state_t r_state;
    wr_state_t w_next;
    logic      w_hit;
    logic      w_commit;
    logic      r_wr_tick;

    assign w_hit = iorq & wr & ce;

    // State register; reset lands in BLOCK so a write already on the bus at
    // release is ignored until it ends.
    always_ff @(posedge phi or negedge reset) begin
        if (!reset) begin
            r_state <= WR_BLOCK;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; the commit strobe is the ARM->COMMIT transition.
    always_comb begin
        w_next   = r_state;
        w_commit = 1'b0;
        case (r_state)
            WR_BLOCK:  w_next = w_hit ? WR_BLOCK : WR_IDLE;
            WR_IDLE:   w_next = w_hit ? WR_ARM : WR_IDLE;
            WR_ARM: begin
                if (w_hit) begin
                    w_next   = WR_COMMIT;
                    w_commit = 1'b1;
                end else begin
                    w_next = WR_IDLE;
                end
            end
            WR_COMMIT: w_next = w_hit ? WR_HOLD : WR_IDLE;
            WR_HOLD:   w_next = w_hit ? WR_HOLD : WR_IDLE;
            default:   w_next = WR_BLOCK;
        endcase
    end

    // Registered write tick, high for the single COMMIT cycle.
    always_ff @(posedge phi or negedge reset) begin
        if (!reset) begin
            r_wr_tick <= 1'b0;
        end else begin
            r_wr_tick <= w_commit;
        end
    end

    assign wr_tick = r_wr_tick;

    vdp_ctl_latch #(
        .REG_BITS  (REG_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_ctl_latch (
        .clk         (phi),
        .rst_n       (reset),
        .i_commit    (w_commit),
        .i_mode      (mode),
        .i_d         (d),
        .i_rd_reset  (rd_reset),
        .o_data_tick (data_tick),
        .o_data_val  (data_val),
        .o_reg_tick  (reg_tick),
        .o_reg_num   (reg_num),
        .o_reg_val   (reg_val),
        .o_addr_tick (addr_tick),
        .o_addr_val  (addr_val),
        .o_addr_wr   (addr_wr),
        .o_toggle    (toggle)
    );

endmodule
`default_nettype wire

// File: tb/tb_iorq_wr_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_iorq_wr_fsm
// Description : Self-checking bench for iorq_wr_fsm: vector table of bus
//               writes with a tick scoreboard, plus hand-written latency,
//               rd_reset and mid-cycle reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iorq_wr_fsm;

    localparam int REG_BITS  = 3;
    localparam int ADDR_BITS = 14;

    // kind: 0 first control byte, 1 data, 2 register, 3 address, 4 no commit
    typedef struct {
        bit        mode;
        logic [7:0] d;
        bit        ce_v;
        int        n;
        bit        rdr_before;
        bit        rdr_commit;
        int        kind;
        logic [7:0] e_data;
        logic [2:0] e_reg_num;
        logic [7:0] e_reg_val;
        logic [13:0] e_addr;
        bit        e_addr_wr;
        bit        e_toggle;
    } vec_t;

    typedef struct {
        int          kind;
        logic [7:0]  data;
        logic [2:0]  reg_num;
        logic [7:0]  reg_val;
        logic [13:0] addr;
        bit          addr_wr;
    } sb_t;

    logic                 phi = 1'b0;
    logic                 reset;
    logic                 iorq, wr, ce, mode, rd_reset;
    logic [7:0]           d;
    logic                 wr_tick, data_tick, reg_tick, addr_tick, addr_wr, toggle;
    logic [7:0]           data_val, reg_val;
    logic [REG_BITS-1:0]  reg_num;
    logic [ADDR_BITS-1:0] addr_val;

    int n_checks = 0;
    int n_pass   = 0;
    sb_t sb_q[$];
    vec_t vecs[13];

    iorq_wr_fsm #(.REG_BITS(REG_BITS), .ADDR_BITS(ADDR_BITS)) dut (
        .phi       (phi),
        .reset     (reset),
        .iorq      (iorq),
        .wr        (wr),
        .ce        (ce),
        .mode      (mode),
        .d         (d),
        .rd_reset  (rd_reset),
        .wr_tick   (wr_tick),
        .data_tick (data_tick),
        .data_val  (data_val),
        .reg_tick  (reg_tick),
        .reg_num   (reg_num),
        .reg_val   (reg_val),
        .addr_tick (addr_tick),
        .addr_val  (addr_val),
        .addr_wr   (addr_wr),
        .toggle    (toggle)
    );

    // 20 MHz phi
    always #25 phi = ~phi;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Tick monitor: every tick must match the head of the scoreboard
    always @(negedge phi) begin
        if (reset === 1'b1 && (wr_tick | data_tick | reg_tick | addr_tick)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_tick", {28'd0, wr_tick, data_tick, reg_tick, addr_tick}, 32'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check("wr_tick", wr_tick, 1);
                check("data_tick", data_tick, (e.kind == 1));
                check("reg_tick", reg_tick, (e.kind == 2));
                check("addr_tick", addr_tick, (e.kind == 3));
                case (e.kind)
                    0: check("first_reg_val", reg_val, e.reg_val);
                    1: check("data_val", data_val, e.data);
                    2: begin
                        check("reg_num", reg_num, e.reg_num);
                        check("reg_val", reg_val, e.reg_val);
                    end
                    3: begin
                        check("addr_val", addr_val, e.addr);
                        check("addr_wr", addr_wr, e.addr_wr);
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic push(input int k, input logic [7:0] dv, input logic [2:0] rn,
                        input logic [7:0] rv, input logic [13:0] a, input bit aw);
        sb_t e;
        e.kind = k; e.data = dv; e.reg_num = rn; e.reg_val = rv; e.addr = a; e.addr_wr = aw;
        sb_q.push_back(e);
    endtask

    task automatic pulse_rd_reset();
        @(posedge phi); #1 rd_reset = 1'b1;
        @(posedge phi); #1 rd_reset = 1'b0;
    endtask

    // Hold hit for n phi samples; optionally pulse rd_reset on the commit edge
    task automatic bus_cycle(input bit m, input logic [7:0] dv, input bit cev,
                             input int n, input bit rdr_commit);
        @(posedge phi); #1;
        mode = m; d = dv; ce = cev; iorq = 1'b1; wr = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge phi); #1;
            rd_reset = (rdr_commit && i == 0);
        end
        iorq = 1'b0; wr = 1'b0; ce = 1'b0; rd_reset = 1'b0;
        repeat (2) @(posedge phi);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0, 8'hA5, 1, 4, 0, 0, 1, 8'hA5, 3'd0, 8'h00, 14'h0000, 0, 0};
        vecs[1]  = '{1, 8'h3C, 1, 4, 0, 0, 0, 8'hA5, 3'd0, 8'h3C, 14'h0000, 0, 1};
        vecs[2]  = '{1, 8'h87, 1, 4, 0, 0, 2, 8'hA5, 3'd7, 8'h3C, 14'h0000, 0, 0};
        vecs[3]  = '{1, 8'h34, 1, 4, 0, 0, 0, 8'hA5, 3'd0, 8'h34, 14'h0000, 0, 1};
        vecs[4]  = '{1, 8'h52, 1, 4, 0, 0, 3, 8'hA5, 3'd0, 8'h34, 14'h1234, 1, 0};
        vecs[5]  = '{1, 8'h34, 1, 4, 0, 0, 0, 8'hA5, 3'd0, 8'h34, 14'h0000, 0, 1};
        vecs[6]  = '{1, 8'h12, 1, 4, 0, 0, 3, 8'hA5, 3'd0, 8'h34, 14'h1234, 0, 0};
        vecs[7]  = '{1, 8'h11, 1, 4, 0, 0, 0, 8'hA5, 3'd0, 8'h11, 14'h0000, 0, 1};
        vecs[8]  = '{1, 8'h22, 1, 4, 1, 0, 0, 8'hA5, 3'd0, 8'h22, 14'h0000, 0, 1};
        vecs[9]  = '{1, 8'h85, 1, 4, 0, 1, 2, 8'hA5, 3'd5, 8'h22, 14'h0000, 0, 0};
        vecs[10] = '{1, 8'hFF, 1, 1, 0, 0, 4, 8'hA5, 3'd0, 8'h22, 14'h0000, 0, 0};
        vecs[11] = '{0, 8'hEE, 0, 4, 0, 0, 4, 8'hA5, 3'd0, 8'h22, 14'h0000, 0, 0};
        vecs[12] = '{0, 8'h3E, 1, 2, 0, 0, 1, 8'h3E, 3'd0, 8'h22, 14'h0000, 0, 0};

        reset = 1'b0; iorq = 1'b0; wr = 1'b0; ce = 1'b0; mode = 1'b0;
        d = 8'h00; rd_reset = 1'b0;
        repeat (3) @(posedge phi);
        #1;
        check("rst_wr_tick", wr_tick, 0);
        check("rst_ticks", {data_tick, reg_tick, addr_tick}, 0);
        check("rst_data_val", data_val, 0);
        check("rst_reg", {reg_num, reg_val}, 0);
        check("rst_addr", {addr_val, addr_wr}, 0);
        check("rst_toggle", toggle, 0);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].rdr_before) pulse_rd_reset();
            if (vecs[i].kind != 4)
                push(vecs[i].kind, vecs[i].e_data, vecs[i].e_reg_num,
                     vecs[i].e_reg_val, vecs[i].e_addr, vecs[i].e_addr_wr);
            bus_cycle(vecs[i].mode, vecs[i].d, vecs[i].ce_v, vecs[i].n, vecs[i].rdr_commit);
            check($sformatf("v%0d_toggle", i), toggle, vecs[i].e_toggle);
            check($sformatf("v%0d_data_val", i), data_val, vecs[i].e_data);
            check($sformatf("v%0d_reg_val", i), reg_val, vecs[i].e_reg_val);
        end

        // Latency: wr_tick on the 2nd edge after hit first sampled, one cycle wide
        push(1, 8'hC3, 3'd0, 8'h22, 14'h0, 0);
        @(posedge phi); #1;
        mode = 1'b0; d = 8'hC3; ce = 1'b1; iorq = 1'b1; wr = 1'b1;
        @(posedge phi); #1 check("lat_edge1", wr_tick, 0);
        @(posedge phi); #1 check("lat_edge2", wr_tick, 1);
        @(posedge phi); #1 check("lat_pulse_end", wr_tick, 0);
        iorq = 1'b0; wr = 1'b0; ce = 1'b0;
        repeat (2) @(posedge phi);
        #1;

        // Mid-cycle reset during HOLD, released while the write is still on the bus
        push(0, 8'h00, 3'd0, 8'h66, 14'h0, 0);
        mode = 1'b1; d = 8'h66; ce = 1'b1; iorq = 1'b1; wr = 1'b1;
        repeat (4) @(posedge phi);
        #1 check("hold_toggle", toggle, 1);
        #5 reset = 1'b0;
        #1;
        check("midrst_toggle", toggle, 0);
        check("midrst_reg_val", reg_val, 0);
        check("midrst_wr_tick", wr_tick, 0);
        @(posedge phi); #1 reset = 1'b1;
        repeat (5) @(posedge phi);
        #1 check("block_no_tick", wr_tick, 0);
        iorq = 1'b0; wr = 1'b0; ce = 1'b0;
        repeat (2) @(posedge phi);
        #1;
        push(1, 8'h5A, 3'd0, 8'h00, 14'h0, 0);
        bus_cycle(1'b0, 8'h5A, 1'b1, 4, 1'b0);
        check("post_rst_data_val", data_val, 8'h5A);
        check("post_rst_toggle", toggle, 0);

        check("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
